// File: rtl/wb_mem_unit.sv
// -----------------------------------------------------------------------------
// wb_mem_unit
//
// Wishbone B4 classic master shared by instruction fetch and load/store in the
// multi-cycle core. The core hands over one request at a time through a
// valid/ready handshake. The unit performs the access and returns one response
// pulse.
//
// Supported features:
//   - byte, halfword, word and doubleword accesses (doubleword only when
//     XLEN = 64), with byte-lane selects;
//   - sign or zero extension of load data;
//   - misalignment detection;
//   - bus error and timeout reporting.
//
// Parameters:
//   XLEN     data/address width, 32 or 64
//   TIMEOUT  cycles a bus cycle may wait for ack/err before it is aborted (>= 2)
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    request handshake; ready is high only while idle
//   req_we             1 = store, 0 = load/fetch
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   req_size           0 byte, 1 half, 2 word, 3 double
//   req_unsigned       zero-extend load data
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores and errors)
//   resp_err           error flag, valid with resp_valid
//   resp_cause         0 ok, 1 misaligned/illegal size, 2 bus error, 3 timeout
//   wb_*               Wishbone master interface; all outputs registered
// -----------------------------------------------------------------------------
module wb_mem_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic [1:0]        resp_cause,
   output logic [XLEN-1:0]   wb_adr_o,
   output logic [XLEN-1:0]   wb_dat_o,
   input  logic [XLEN-1:0]   wb_dat_i,
   output logic [XLEN/8-1:0] wb_sel_o,
   output logic              wb_we_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);

   localparam int SELW = XLEN / 8;
   localparam int OFFW = $clog2(SELW);
   localparam int CNTW = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] CAUSE_OK      = 2'd0;
   localparam logic [1:0] CAUSE_ALIGN   = 2'd1;
   localparam logic [1:0] CAUSE_BUSERR  = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic [OFFW-1:0]   offset_q, offset_d;
   logic              ready_q, ready_d;
   logic              respValid_q, respValid_d;
   logic [XLEN-1:0]   respRdata_q, respRdata_d;
   logic              respErr_q, respErr_d;
   logic [1:0]        respCause_q, respCause_d;
   logic [XLEN-1:0]   adr_q, adr_d;
   logic [XLEN-1:0]   dat_q, dat_d;
   logic [SELW-1:0]   sel_q, sel_d;
   logic              we_q, we_d;
   logic              cyc_q, cyc_d;
   logic              stb_q, stb_d;

   // An access is misaligned when its address is not a multiple of its size.
   // A doubleword on a 32-bit bus can never be served and is rejected the same way.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [XLEN-1:0] addr);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = addr[0];
         2'd2:    bad = |addr[1:0];
         default: bad = (XLEN == 32) || (|addr[2:0]);
      endcase
      return bad;
   endfunction

   // Byte-lane select: a run of 2^size ones starting at the byte offset.
   function automatic logic [SELW-1:0] laneSel(input logic [1:0] size, input logic [OFFW-1:0] off);
      logic [15:0] ones;
      case (size)
         2'd0:    ones = 16'h0001;
         2'd1:    ones = 16'h0003;
         2'd2:    ones = 16'h000F;
         default: ones = 16'h00FF;
      endcase
      ones = ones << off;
      return ones[SELW-1:0];
   endfunction

   // Copy the low 2^size bytes of the store data into every lane. The slave
   // then picks the correct bytes using wb_sel_o, whatever the offset.
   function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] wdata, input logic [1:0] size);
      logic [XLEN-1:0] r;
      int              laneMask;
      laneMask = (1 << size) - 1;
      r = '0;
      for (int i = 0; i < SELW; i++) begin
         r[i*8 +: 8] = wdata[(i & laneMask)*8 +: 8];
      end
      return r;
   endfunction

   // Move the addressed lanes down to bit 0, mask to the access size and
   // sign-extend unless the load is unsigned or already fills the register.
   function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] busData,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [1:0]      size,
                                                  input logic            uns);
      logic [XLEN-1:0] shifted;
      logic [XLEN-1:0] mask;
      logic [XLEN-1:0] result;
      int              nbits;
      shifted = busData >> {off, 3'b000};
      nbits   = 8 << size;
      mask    = '1;
      if (nbits < XLEN) begin
         mask = ~({XLEN{1'b1}} << nbits);
      end
      result = shifted & mask;
      if (!uns && (nbits < XLEN) && shifted[nbits-1]) begin
         result = result | ~mask;
      end
      return result;
   endfunction

   // State and output registers. Reset clears everything, drops an in-flight
   // bus cycle on the same edge and discards the pending response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         size_q      <= '0;
         unsigned_q  <= 1'b0;
         offset_q    <= '0;
         ready_q     <= 1'b0;
         respValid_q <= 1'b0;
         respRdata_q <= '0;
         respErr_q   <= 1'b0;
         respCause_q <= CAUSE_OK;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         offset_q    <= offset_d;
         ready_q     <= ready_d;
         respValid_q <= respValid_d;
         respRdata_q <= respRdata_d;
         respErr_q   <= respErr_d;
         respCause_q <= respCause_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
      end
   end

   // Next-state and next-output logic. The response fields default to zero, so
   // resp_valid is high only in the RESP cycle and resp_rdata stays 0 for
   // stores and errors. In BUS the priority is bus error, then ack, then
   // timeout. As a result an ack on the last allowed cycle still completes normally.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      offset_d    = offset_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      we_d        = we_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      respValid_d = 1'b0;
      respRdata_d = '0;
      respErr_d   = 1'b0;
      respCause_d = CAUSE_OK;

      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               size_d     = req_size;
               unsigned_d = req_unsigned;
               offset_d   = req_addr[OFFW-1:0];
               cnt_d      = '0;
               if (isMisaligned(req_size, req_addr)) begin
                  state_d     = RESP;
                  respValid_d = 1'b1;
                  respErr_d   = 1'b1;
                  respCause_d = CAUSE_ALIGN;
               end else begin
                  state_d = BUS;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  we_d    = req_we;
                  adr_d   = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                  sel_d   = laneSel(req_size, req_addr[OFFW-1:0]);
                  dat_d   = replicate(req_wdata, req_size);
               end
            end
         end

         BUS: begin
            cnt_d = cnt_q + CNTW'(1);
            if (wb_err_i || wb_ack_i || (cnt_q == CNTW'(TIMEOUT - 1))) begin
               state_d     = RESP;
               respValid_d = 1'b1;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               sel_d       = '0;
               if (wb_err_i) begin
                  respErr_d   = 1'b1;
                  respCause_d = CAUSE_BUSERR;
               end else if (wb_ack_i) begin
                  respCause_d = CAUSE_OK;
                  if (!we_q) begin
                     respRdata_d = extendLoad(wb_dat_i, offset_q, size_q, unsigned_q);
                  end
               end else begin
                  respErr_d   = 1'b1;
                  respCause_d = CAUSE_TIMEOUT;
               end
            end
         end

         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   assign req_ready  = ready_q;
   assign resp_valid = respValid_q;
   assign resp_rdata = respRdata_q;
   assign resp_err   = respErr_q;
   assign resp_cause = respCause_q;
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_q;
   assign wb_sel_o   = sel_q;
   assign wb_we_o    = we_q;
   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = stb_q;

endmodule

// File: tb/tb_wb_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_unit
//
// Drives a 32-bit and a 64-bit wb_mem_unit from one shared stimulus.
// use64 selects the active instance. A single monitor process plays the
// Wishbone slave and compares the selected instance against expectations.
// Those expectations come from a transaction-level model of the unit.
// -----------------------------------------------------------------------------
module tb_wb_mem_unit;

   localparam int TMO    = 16;
   localparam int M_ACK  = 0;
   localparam int M_ERR  = 1;
   localparam int M_BOTH = 2;
   localparam int M_NONE = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        use64;
   logic        reqValid, reqWe, reqUns;
   logic [63:0] reqAddr, reqWdata;
   logic [1:0]  reqSize;
   logic [63:0] busData;
   logic        slvAck, slvErr;

   logic        ready32, rv32, rerr32, we32, cyc32, stb32;
   logic [31:0] rdata32, adr32, dat32;
   logic [1:0]  cause32;
   logic [3:0]  sel32;

   logic        ready64, rv64, rerr64, we64, cyc64, stb64;
   logic [63:0] rdata64, adr64, dat64;
   logic [1:0]  cause64;
   logic [7:0]  sel64;

   wb_mem_unit #(.XLEN(32), .TIMEOUT(TMO)) dut32 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid & ~use64), .req_ready(ready32), .req_we(reqWe),
      .req_addr(reqAddr[31:0]), .req_wdata(reqWdata[31:0]), .req_size(reqSize),
      .req_unsigned(reqUns),
      .resp_valid(rv32), .resp_rdata(rdata32), .resp_err(rerr32), .resp_cause(cause32),
      .wb_adr_o(adr32), .wb_dat_o(dat32), .wb_dat_i(busData[31:0]), .wb_sel_o(sel32),
      .wb_we_o(we32), .wb_cyc_o(cyc32), .wb_stb_o(stb32),
      .wb_ack_i(slvAck & ~use64), .wb_err_i(slvErr & ~use64)
   );

   wb_mem_unit #(.XLEN(64), .TIMEOUT(TMO)) dut64 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid & use64), .req_ready(ready64), .req_we(reqWe),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_size(reqSize),
      .req_unsigned(reqUns),
      .resp_valid(rv64), .resp_rdata(rdata64), .resp_err(rerr64), .resp_cause(cause64),
      .wb_adr_o(adr64), .wb_dat_o(dat64), .wb_dat_i(busData), .wb_sel_o(sel64),
      .wb_we_o(we64), .wb_cyc_o(cyc64), .wb_stb_o(stb64),
      .wb_ack_i(slvAck & use64), .wb_err_i(slvErr & use64)
   );

   // Outputs of the currently selected instance, widened to 64 bits.
   logic        mReady, mRespValid, mErr, mWe, mCyc, mStb;
   logic [63:0] mRdata, mAdr, mDat, mSel;
   logic [1:0]  mCause;
   assign mReady     = use64 ? ready64 : ready32;
   assign mRespValid = use64 ? rv64    : rv32;
   assign mErr       = use64 ? rerr64  : rerr32;
   assign mWe        = use64 ? we64    : we32;
   assign mCyc       = use64 ? cyc64   : cyc32;
   assign mStb       = use64 ? stb64   : stb32;
   assign mRdata     = use64 ? rdata64 : {32'b0, rdata32};
   assign mAdr       = use64 ? adr64   : {32'b0, adr32};
   assign mDat       = use64 ? dat64   : {32'b0, dat32};
   assign mSel       = use64 ? {56'b0, sel64} : {60'b0, sel32};
   assign mCause     = use64 ? cause64 : cause32;

   int errors = 0;
   int checks = 0;

   int          cycleCnt = 0, acceptCycle = 0, stbCount = 0, respCount = 0;
   bit          inFlight = 1'b0, monOff = 1'b1;
   int          expMode, expWaits, expStb, expLat;
   logic [63:0] expAdr, expSel, expDat, expRdata;
   logic        expWe, expErr;
   logic [1:0]  expCause;
   logic [63:0] lastSel, lastAdr, lastDat, lastRdata;
   logic        lastWe, lastErr;
   logic [1:0]  lastCause;
   int          lastStb, lastLat;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   function automatic bit modelMisaligned(input int xl, input logic [63:0] addr, input int n);
      return (8 * n > xl) || ((addr % n) != 0);
   endfunction

   function automatic logic [63:0] modelAdr(input int xl, input logic [63:0] addr);
      logic [63:0] a;
      a = addr - (addr % (xl / 8));
      if (xl == 32) a = a & 64'hFFFF_FFFF;
      return a;
   endfunction

   function automatic logic [63:0] modelSel(input int xl, input logic [63:0] addr, input int n);
      logic [63:0] s;
      int          o;
      o = int'(addr % (xl / 8));
      s = '0;
      for (int i = 0; i < xl / 8; i++) begin
         if (i >= o && i < o + n) s[i] = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [63:0] modelDat(input int xl, input logic [63:0] wdata, input int n);
      logic [63:0] d;
      d = '0;
      for (int i = 0; i < xl / 8; i++) begin
         d[i*8 +: 8] = wdata[(i % n)*8 +: 8];
      end
      return d;
   endfunction

   function automatic logic [63:0] modelRdata(input int xl, input logic [63:0] bus,
                                             input logic [63:0] addr, input int n, input bit uns);
      logic [63:0] v;
      int          o;
      o = int'(addr % (xl / 8));
      v = bus >> (8 * o);
      if (n < 8) v = v % (64'd1 << (8 * n));
      if (!uns && (8 * n < xl) && v[8*n-1]) v = v - (64'd1 << (8 * n));
      if (xl == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   // ---------------- slave + compare process ----------------
   always @(negedge clk) begin
      if (!monOff) begin
         cycleCnt++;
         checkOutput("req_ready", {63'b0, mReady}, {63'b0, !inFlight});
         if (!inFlight) checkOutput("resp_valid_idle", {63'b0, mRespValid}, 64'd0);
         if (mStb) begin
            stbCount++;
            checkOutput("wb_cyc", {63'b0, mCyc}, 64'd1);
            checkOutput("wb_adr", mAdr, expAdr);
            checkOutput("wb_sel", mSel, expSel);
            checkOutput("wb_we", {63'b0, mWe}, {63'b0, expWe});
            if (expWe) checkOutput("wb_dat", mDat, expDat);
            lastSel = mSel; lastAdr = mAdr; lastDat = mDat; lastWe = mWe;
            slvAck  = (expMode == M_ACK || expMode == M_BOTH) && (stbCount > expWaits);
            slvErr  = (expMode == M_ERR || expMode == M_BOTH) && (stbCount > expWaits);
         end else begin
            checkOutput("wb_cyc_idle", {63'b0, mCyc}, 64'd0);
            checkOutput("wb_sel_idle", mSel, 64'd0);
            slvAck = 1'b0;
            slvErr = 1'b0;
         end
         if (inFlight && mRespValid) begin
            checkOutput("resp_rdata", mRdata, expRdata);
            checkOutput("resp_err", {63'b0, mErr}, {63'b0, expErr});
            checkOutput("resp_cause", {62'b0, mCause}, {62'b0, expCause});
            checkOutput("stb_cycles", 64'(stbCount), 64'(expStb));
            checkOutput("latency", 64'(cycleCnt - acceptCycle), 64'(expLat));
            lastRdata = mRdata; lastErr = mErr; lastCause = mCause;
            lastStb = stbCount; lastLat = cycleCnt - acceptCycle;
            respCount++;
            inFlight = 1'b0;
         end
      end
   end

   // One request through the handshake; expectations are set up before accept.
   task automatic applyStimulus(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [1:0] size, input bit uns, input int mode,
                                input int waits, input logic [63:0] bus);
      int xl, n, startCount, waitCnt;
      bit mis;
      xl = use64 ? 64 : 32;
      n  = 1 << size;
      @(negedge clk); #2;
      mis      = modelMisaligned(xl, addr, n);
      expAdr   = modelAdr(xl, addr);
      expSel   = modelSel(xl, addr, n);
      expDat   = modelDat(xl, wdata, n);
      expWe    = we;
      expMode  = mode;
      expWaits = waits;
      expRdata = 64'd0;
      if (mis) begin
         expErr = 1'b1; expCause = 2'd1; expStb = 0; expLat = 1;
      end else if (mode == M_NONE) begin
         expErr = 1'b1; expCause = 2'd3; expStb = TMO; expLat = TMO + 1;
      end else if (mode == M_ACK) begin
         expErr = 1'b0; expCause = 2'd0; expStb = waits + 1; expLat = waits + 2;
         if (!we) expRdata = modelRdata(xl, bus, addr, n, uns);
      end else begin
         expErr = 1'b1; expCause = 2'd2; expStb = waits + 1; expLat = waits + 2;
      end
      busData  = bus;
      reqWe    = we;
      reqAddr  = addr;
      reqWdata = wdata;
      reqSize  = size;
      reqUns   = uns;
      reqValid = 1'b1;
      @(posedge clk); #1;
      reqValid    = 1'b0;
      reqAddr     = {$urandom, $urandom};
      reqWdata    = {$urandom, $urandom};
      reqSize     = 2'($urandom);
      reqUns      = 1'($urandom);
      reqWe       = 1'($urandom);
      acceptCycle = cycleCnt;
      stbCount    = 0;
      inFlight    = 1'b1;
      startCount  = respCount;
      waitCnt     = 0;
      while (respCount == startCount && waitCnt < 40) begin
         @(negedge clk); #3;
         waitCnt++;
      end
      if (respCount == startCount) begin
         checkOutput("resp_never_arrived", 64'(respCount), 64'(startCount + 1));
         inFlight = 1'b0;
      end
   endtask

   task automatic resetInit();
      monOff = 1'b1; rst = 1'b1; reqValid = 1'b0; slvAck = 1'b0; slvErr = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready32", {63'b0, ready32}, 64'd0);
      checkOutput("rst_ready64", {63'b0, ready64}, 64'd0);
      checkOutput("rst_cyc32", {63'b0, cyc32}, 64'd0);
      checkOutput("rst_stb64", {63'b0, stb64}, 64'd0);
      checkOutput("rst_resp32", {63'b0, rv32}, 64'd0);
      checkOutput("rst_adr64", adr64, 64'd0);
      checkOutput("rst_sel32", {60'b0, sel32}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready32_after_rst", {63'b0, ready32}, 64'd1);
      checkOutput("ready64_after_rst", {63'b0, ready64}, 64'd1);
      inFlight = 1'b0;
      monOff   = 1'b0;
   endtask

   // Load that the slave never answers, with reset asserted while it is on the bus.
   task automatic resetMidOp();
      int xl;
      xl = use64 ? 64 : 32;
      @(negedge clk); #2;
      expAdr = modelAdr(xl, 64'h2000); expSel = modelSel(xl, 64'h2000, 4);
      expWe = 1'b0; expMode = M_NONE; expWaits = 0;
      reqWe = 1'b0; reqAddr = 64'h2000; reqSize = 2'd2; reqUns = 1'b0; reqValid = 1'b1;
      @(posedge clk); #1;
      reqValid = 1'b0; acceptCycle = cycleCnt; stbCount = 0; inFlight = 1'b1;
      repeat (3) begin @(negedge clk); #3; end
      checkOutput("stb_before_rst", {63'b0, mStb}, 64'd1);
      monOff = 1'b1; slvAck = 1'b0; slvErr = 1'b0; rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_midop_cyc", {63'b0, mCyc}, 64'd0);
      checkOutput("rst_midop_stb", {63'b0, mStb}, 64'd0);
      repeat (2) begin
         checkOutput("rst_midop_resp", {63'b0, mRespValid}, 64'd0);
         checkOutput("rst_midop_ready", {63'b0, mReady}, 64'd0);
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_midop_rst", {63'b0, mReady}, 64'd1);
      checkOutput("no_resp_after_rst", {63'b0, mRespValid}, 64'd0);
      inFlight = 1'b0;
      monOff   = 1'b0;
   endtask

   task automatic randomRun(input int count);
      logic [63:0] addr;
      logic [1:0]  size;
      int          n, pick, mode;
      for (int t = 0; t < count; t++) begin
         size = 2'($urandom);
         n    = 1 << size;
         addr = use64 ? {32'b0, $urandom} : {48'b0, 16'($urandom)};
         if ($urandom % 10 < 7) addr = addr - (addr % n);
         pick = $urandom % 20;
         mode = (pick < 13) ? M_ACK : (pick < 16) ? M_ERR : (pick < 19) ? M_BOTH : M_NONE;
         applyStimulus(1'($urandom), addr, {$urandom, $urandom}, size, 1'($urandom),
                       mode, $urandom % 4, {$urandom, $urandom});
      end
   endtask

   initial begin
      use64 = 1'b0; rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqUns = 1'b0;
      reqAddr = '0; reqWdata = '0; reqSize = '0; busData = '0; slvAck = 1'b0; slvErr = 1'b0;
      resetInit();

      // ---- XLEN = 32 directed ----
      applyStimulus(1'b0, 64'h100, 64'h0, 2'd2, 1'b0, M_ACK, 0, 64'hDEADBEEF);
      checkOutput("lw_sel", lastSel, 64'hF);
      checkOutput("lw_adr", lastAdr, 64'h100);
      checkOutput("lw_rdata", lastRdata, 64'hDEADBEEF);
      checkOutput("lw_err", {63'b0, lastErr}, 64'd0);
      checkOutput("lw_latency", 64'(lastLat), 64'd2);

      applyStimulus(1'b0, 64'h203, 64'h0, 2'd0, 1'b0, M_ACK, 0, 64'h80FF_FF7F);
      checkOutput("lb_sel", lastSel, 64'h8);
      checkOutput("lb_rdata", lastRdata, 64'hFFFF_FF80);
      applyStimulus(1'b0, 64'h203, 64'h0, 2'd0, 1'b1, M_ACK, 0, 64'h80FF_FF7F);
      checkOutput("lbu_rdata", lastRdata, 64'h0000_0080);

      applyStimulus(1'b1, 64'h302, 64'h1234ABCD, 2'd1, 1'b0, M_ACK, 1, 64'h5555_AAAA);
      checkOutput("sh_adr", lastAdr, 64'h300);
      checkOutput("sh_sel", lastSel, 64'hC);
      checkOutput("sh_dat", lastDat, 64'hABCD_ABCD);
      checkOutput("sh_we", {63'b0, lastWe}, 64'd1);
      checkOutput("sh_rdata", lastRdata, 64'd0);

      applyStimulus(1'b0, 64'h101, 64'h0, 2'd2, 1'b0, M_ACK, 0, 64'h1);
      checkOutput("mis_stb", 64'(lastStb), 64'd0);
      checkOutput("mis_cause", {62'b0, lastCause}, 64'd1);
      checkOutput("mis_err", {63'b0, lastErr}, 64'd1);
      checkOutput("mis_latency", 64'(lastLat), 64'd1);
      applyStimulus(1'b0, 64'h100, 64'h0, 2'd3, 1'b0, M_ACK, 0, 64'h1);
      checkOutput("size3_cause", {62'b0, lastCause}, 64'd1);
      checkOutput("size3_stb", 64'(lastStb), 64'd0);

      applyStimulus(1'b0, 64'h40, 64'h0, 2'd2, 1'b0, M_NONE, 0, 64'h1);
      checkOutput("tmo_stb", 64'(lastStb), 64'd16);
      checkOutput("tmo_cause", {62'b0, lastCause}, 64'd3);
      applyStimulus(1'b0, 64'h40, 64'h0, 2'd2, 1'b0, M_BOTH, 2, 64'h1);
      checkOutput("both_cause", {62'b0, lastCause}, 64'd2);
      checkOutput("both_rdata", lastRdata, 64'd0);
      applyStimulus(1'b0, 64'h40, 64'h0, 2'd2, 1'b0, M_ACK, 15, 64'h1122_3344);
      checkOutput("late_ack_cause", {62'b0, lastCause}, 64'd0);
      checkOutput("late_ack_stb", 64'(lastStb), 64'd16);
      checkOutput("late_ack_rdata", lastRdata, 64'h1122_3344);

      randomRun(150);

      // ---- XLEN = 64 ----
      @(negedge clk); #2;
      use64 = 1'b1;
      applyStimulus(1'b0, 64'h1004, 64'h0, 2'd2, 1'b0, M_ACK, 0, 64'h8000_0001_0000_0000);
      checkOutput("lw64_sel", lastSel, 64'hF0);
      checkOutput("lw64_rdata", lastRdata, 64'hFFFF_FFFF_8000_0001);
      applyStimulus(1'b1, 64'h1007, 64'hAB, 2'd0, 1'b0, M_ACK, 0, 64'h0);
      checkOutput("sb64_sel", lastSel, 64'h80);
      checkOutput("sb64_dat", lastDat, 64'hABAB_ABAB_ABAB_ABAB);
      applyStimulus(1'b0, 64'h1008, 64'h0, 2'd3, 1'b0, M_ACK, 0, 64'hF123_4567_89AB_CDEF);
      checkOutput("ld64_sel", lastSel, 64'hFF);
      checkOutput("ld64_rdata", lastRdata, 64'hF123_4567_89AB_CDEF);

      resetMidOp();
      randomRun(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
